// File: rtl/param_sync_fifo.sv
// Parameterised synchronous FIFO with registered read data and status flags.
// Sticky overflow/underflow flags exist only with PARAM_SYNC_FIFO_ERR_FLAGS_EN.
module param_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int AF_LEVEL   = DEPTH - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    wren,
  input  logic                    rden,
  input  logic [DATA_WIDTH-1:0]   i_data,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] o_data_q, o_data_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  wr_acc, rd_acc;

  always_comb begin
    full         = (count_q == DEPTH_C);
    empty        = (count_q == '0);
    almost_full  = (count_q >= AF_C);
    almost_empty = (count_q <= AE_C);
    wr_acc       = wren && !full && !flush;
    rd_acc       = rden && !empty && !flush;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    o_data_d = o_data_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are power-of-two wide, so increment wraps with no gap
      if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
      if (rd_acc) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        o_data_d = mem_q[rd_ptr_q];
      end
      unique case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      o_data_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      o_data_q <= o_data_d;
    end
  end

  // Storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (wr_acc && !rst) mem_q[wr_ptr_q] <= i_data;
  end

  assign o_data = o_data_q;
  assign count  = count_q;

`ifdef PARAM_SYNC_FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (flush) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wren && full)  overflow_d  = 1'b1;
      if (rden && empty) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// Self-checking bench for param_sync_fifo (DEPTH=8, AF=6, AE=1).
// Table vectors, corner sequences, then random traffic against a queue model.
module tb_param_sync_fifo;

`ifdef PARAM_SYNC_FIFO_ERR_FLAGS_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       wren = 1'b0;
  logic       rden = 1'b0;
  logic [7:0] i_data = '0;
  logic [7:0] o_data;
  logic       full, empty, almost_full, almost_empty;
  logic [3:0] count;
  logic       overflow, underflow;

  param_sync_fifo #(
    .DATA_WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(1)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush), .wren(wren), .rden(rden),
    .i_data(i_data), .o_data(o_data), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural reference
  logic [7:0] mq[$];
  logic [7:0] m_o   = '0;
  bit         m_ovf = 1'b0;
  bit         m_udf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit r, input bit f, input bit w, input bit rd,
                     input logic [7:0] d);
    bit m_full, m_empty;
    rst = r; flush = f; wren = w; rden = rd; i_data = d;
    @(posedge clk);
    if (r) begin
      mq.delete(); m_o = '0; m_ovf = 0; m_udf = 0;
    end else if (f) begin
      mq.delete(); m_ovf = 0; m_udf = 0;
    end else begin
      m_full  = (mq.size() == 8);
      m_empty = (mq.size() == 0);
      if (w && m_full)   m_ovf = 1;
      if (rd && m_empty) m_udf = 1;
      if (rd && !m_empty) m_o = mq.pop_front();
      if (w && !m_full)  mq.push_back(d);
    end
    #1;
    rst = 0; flush = 0; wren = 0; rden = 0;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".count"}, 32'(count), 32'(mq.size()));
    chk({tag, ".o_data"}, 32'(o_data), 32'(m_o));
    chk({tag, ".full"}, 32'(full), 32'(mq.size() == 8));
    chk({tag, ".empty"}, 32'(empty), 32'(mq.size() == 0));
    chk({tag, ".af"}, 32'(almost_full), 32'(mq.size() >= 6));
    chk({tag, ".ae"}, 32'(almost_empty), 32'(mq.size() <= 1));
    chk({tag, ".ovf"}, 32'(overflow), 32'(ERR & m_ovf));
    chk({tag, ".udf"}, 32'(underflow), 32'(ERR & m_udf));
  endtask

  typedef struct {
    bit         r, f, w, rd;
    logic [7:0] d;
    int         e_cnt;
    logic [7:0] e_o;
    bit         e_full, e_empty;
  } vec_t;

  vec_t tbl[17];

  initial begin
    logic [7:0] held;
    bit ae_e[6] = '{1, 1, 0, 0, 0, 0};
    bit af_e[6] = '{0, 0, 0, 0, 1, 1};
    int lv[6]   = '{0, 1, 2, 5, 6, 8};

    // Reset, 8 writes 0x11..0x88, 8 reads
    tbl[0] = '{1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 1};
    for (int i = 1; i <= 8; i++)
      tbl[i] = '{0, 0, 1, 0, 8'(8'h11 * i), i, 8'h00, (i == 8), 0};
    for (int k = 1; k <= 8; k++)
      tbl[8+k] = '{0, 0, 0, 1, 8'h00, 8 - k, 8'(8'h11 * k), 0, (k == 8)};

    for (int i = 0; i < 17; i++) begin
      cyc(tbl[i].r, tbl[i].f, tbl[i].w, tbl[i].rd, tbl[i].d);
      chk($sformatf("tbl%0d.count", i), 32'(count), 32'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d.o_data", i), 32'(o_data), 32'(tbl[i].e_o));
      chk($sformatf("tbl%0d.full", i), 32'(full), 32'(tbl[i].e_full));
      chk($sformatf("tbl%0d.empty", i), 32'(empty), 32'(tbl[i].e_empty));
    end
    chk("rst.ovf", 32'(overflow), 32'(0));
    chk("rst.udf", 32'(underflow), 32'(0));

    // Write rejected when full, simultaneous read completes
    for (int i = 0; i < 8; i++) cyc(0, 0, 1, 0, 8'(8'hA0 + i));
    cyc(0, 0, 1, 1, 8'h99);
    chk("ovf_seq.o_data", 32'(o_data), 32'h A0);
    chk("ovf_seq.count", 32'(count), 32'(7));
    chk("ovf_seq.ovf", 32'(overflow), 32'(ERR));
    cyc(0, 0, 1, 0, 8'h99);
    chk("ovf_seq.count2", 32'(count), 32'(8));
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0, 1, 8'h00);
      chk_model("drain");
    end
    chk("ovf_seq.last", 32'(o_data), 32'h99);

    // Read rejected when empty, no fall-through
    cyc(0, 0, 1, 1, 8'h5A);
    chk("udf_seq.o_data", 32'(o_data), 32'h99);
    chk("udf_seq.count", 32'(count), 32'(1));
    chk("udf_seq.udf", 32'(underflow), 32'(ERR));
    cyc(0, 0, 0, 1, 8'h00);
    chk("udf_seq.read", 32'(o_data), 32'h5A);

    // Steady simultaneous traffic at count 3, pointers wrap
    cyc(0, 1, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 8'(8'h30 + i));
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0, 1, 1, 8'(8'h40 + i));
      chk($sformatf("rw%0d.count", i), 32'(count), 32'(3));
      chk_model("rw");
    end

    // Threshold flags
    cyc(0, 1, 0, 0, 8'h00);
    for (int j = 0; j < 6; j++) begin
      while (int'(count) < lv[j]) cyc(0, 0, 1, 0, 8'($urandom));
      chk($sformatf("lvl%0d.ae", lv[j]), 32'(almost_empty), 32'(ae_e[j]));
      chk($sformatf("lvl%0d.af", lv[j]), 32'(almost_full), 32'(af_e[j]));
    end

    // Flush at count 5 with wren high clears flags and holds o_data
    cyc(0, 1, 0, 0, 8'h00);
    cyc(0, 0, 0, 1, 8'h00);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 8'(8'h60 + i));
    cyc(0, 0, 0, 1, 8'h00);
    cyc(0, 0, 1, 0, 8'h65);
    held = o_data;
    chk("fl.pre_count", 32'(count), 32'(5));
    cyc(0, 1, 1, 0, 8'hEE);
    chk("fl.count", 32'(count), 32'(0));
    chk("fl.empty", 32'(empty), 32'(1));
    chk("fl.o_data", 32'(o_data), 32'h60);
    chk("fl.held", 32'(o_data), 32'(held));
    chk("fl.udf", 32'(underflow), 32'(0));
    chk("fl.ovf", 32'(overflow), 32'(0));

    // Reset mid-stream at count 4
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, 8'(8'h70 + i));
    cyc(0, 0, 0, 1, 8'h00);
    cyc(0, 0, 1, 0, 8'h74);
    chk("rs.pre_count", 32'(count), 32'(4));
    cyc(1, 1, 1, 1, 8'hFF);
    chk("rs.count", 32'(count), 32'(0));
    chk("rs.o_data", 32'(o_data), 32'(0));
    chk("rs.empty", 32'(empty), 32'(1));
    chk("rs.ae", 32'(almost_empty), 32'(1));
    chk("rs.full", 32'(full), 32'(0));
    chk("rs.af", 32'(almost_full), 32'(0));
    cyc(0, 0, 1, 0, 8'hC3);
    chk("post_rst.count", 32'(count), 32'(1));
    cyc(0, 0, 0, 1, 8'h00);
    chk("post_rst.o_data", 32'(o_data), 32'hC3);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom % 97) == 0, ($urandom % 23) == 0,
          ($urandom % 100) < 55, ($urandom % 100) < 50,
          8'($urandom));
      chk_model("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
